// File: rtl/vc_buffer_array_if.sv
// vc_buffer_array_if
// Flit bus of one router input port: the link-side write channel and the
// switch-side read channel of the virtual-channel buffer.
//
//   master : the surroundings (link receiver + switch); drives in_*, out_ready
//   slave  : the buffer itself; drives in_ready, out_*, vc_empty
//
// Signals
//   in_data/in_vc/in_valid/in_head/in_tail : incoming flit and its target VC
//   in_ready[NUM_VC]                      : per-VC not-full
//   out_data/out_vc/out_valid/out_head/out_tail : presented flit
//   out_ready                             : switch takes the presented flit
//   vc_empty[NUM_VC]                      : per-VC empty
interface vc_buffer_array_if #(
    parameter int DATA_W = 32,
    parameter int NUM_VC = 4
);
    localparam int VC_W = $clog2(NUM_VC);

    logic [DATA_W-1:0] in_data;
    logic [VC_W-1:0]   in_vc;
    logic              in_valid;
    logic              in_head;
    logic              in_tail;
    logic [NUM_VC-1:0] in_ready;

    logic [DATA_W-1:0] out_data;
    logic [VC_W-1:0]   out_vc;
    logic              out_valid;
    logic              out_head;
    logic              out_tail;
    logic              out_ready;

    logic [NUM_VC-1:0] vc_empty;

    modport master (
        output in_data, in_vc, in_valid, in_head, in_tail, out_ready,
        input  in_ready, out_data, out_vc, out_valid, out_head, out_tail, vc_empty
    );

    modport slave (
        input  in_data, in_vc, in_valid, in_head, in_tail, out_ready,
        output in_ready, out_data, out_vc, out_valid, out_head, out_tail, vc_empty
    );
endinterface

// File: rtl/vc_buffer_array.sv
// vc_buffer_array
// Virtual-channel input buffer for one router input port. NUM_VC independent
// FIFOs of DEPTH flits (payload + head/tail flags); one flit per cycle is
// presented to the switch from the VC held in the sel register, which is
// moved by a round-robin arbiter.
//
// Optional feature (macro VC_PKT_LOCK_EN):
//   defined   - wormhole locking: the arbiter stays on a VC from head to tail
//   undefined - no lock register, flit-level round robin
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : vc_buffer_array_if.slave (write channel, read channel, status)
module vc_buffer_array #(
    parameter int DATA_W = 32,
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    vc_buffer_array_if.slave  bus
);
    localparam int VC_W  = $clog2(NUM_VC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;

    logic [ENT_W-1:0]  mem_q    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [CNT_W-1:0]  cnt_q    [NUM_VC];
    logic [CNT_W-1:0]  cnt_d    [NUM_VC];
    logic [VC_W-1:0]   sel_q, sel_d;

    logic [NUM_VC-1:0] full, empty, wr_vec, rd_vec;
    logic              in_range, wr_en, rd_en, upd, lock_d, found;
    logic [ENT_W-1:0]  head_ent;
    int                cand;

    always_comb begin
        for (int k = 0; k < NUM_VC; k++) begin
            full[k]  = (cnt_q[k] == CNT_W'(DEPTH));
            empty[k] = (cnt_q[k] == '0);
        end
    end

    // Ready comes from registered counts only: a full VC refuses a write even
    // if the same cycle drains it.
    assign bus.in_ready = ~full;
    assign bus.vc_empty = empty;

    assign in_range = (int'(bus.in_vc) < NUM_VC);
    assign wr_en    = bus.in_valid && in_range && !full[bus.in_vc];
    assign wr_vec   = wr_en ? (NUM_VC'(1) << bus.in_vc) : '0;

    assign head_ent      = mem_q[sel_q][rd_ptr_q[sel_q]];
    assign bus.out_valid = !empty[sel_q];
    assign bus.out_vc    = sel_q;
    assign bus.out_data  = bus.out_valid ? head_ent[DATA_W-1:0] : '0;
    assign bus.out_tail  = bus.out_valid ? head_ent[DATA_W]     : 1'b0;
    assign bus.out_head  = bus.out_valid ? head_ent[DATA_W+1]   : 1'b0;

    assign rd_en  = bus.out_valid && bus.out_ready;
    assign rd_vec = rd_en ? (NUM_VC'(1) << sel_q) : '0;
    assign upd    = rd_en || !bus.out_valid;

    always_comb begin
        for (int k = 0; k < NUM_VC; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(wr_vec[k]) - CNT_W'(rd_vec[k]);
        end
    end

`ifdef VC_PKT_LOCK_EN
    logic lock_q;

    always_comb begin
        lock_d = lock_q;
        if (rd_en) begin
            if (bus.out_tail) begin
                lock_d = 1'b0;
            end else if (bus.out_head) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign lock_d = 1'b0;
`endif

    // Arbiter looks at the next-cycle lock so that the head transfer itself
    // already pins sel, and the tail transfer already releases it. Candidates
    // are scanned from sel+1 with sel last, using post-update counts.
    always_comb begin
        sel_d = sel_q;
        found = 1'b0;
        cand  = 0;
        if (upd && !lock_d) begin
            for (int i = 1; i <= NUM_VC; i++) begin
                cand = (int'(sel_q) + i) % NUM_VC;
                if (!found && cnt_d[cand] != '0) begin
                    sel_d = VC_W'(cand);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_VC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            sel_q <= '0;
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (wr_vec[k]) begin
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                end
                if (rd_vec[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                end
                cnt_q[k] <= cnt_d[k];
            end
            sel_q <= sel_d;
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.in_vc][wr_ptr_q[bus.in_vc]] <= {bus.in_head, bus.in_tail, bus.in_data};
        end
    end
endmodule
